// File: rtl/calc_sequencer.sv
// calc_sequencer: keypad-driven control sequencer for the calculator ALU.
// Builds two signed decimal operands (up to MAX_DIGITS digits each, with sign
// toggle) and an operator from a key stream. On equals it drives a 5-stage
// equal-pulse strobe to the ALU, captures the signed answer and holds it.
//
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   key_valid_i/key_code_i  key handshake input (0-9 digit, A neg, B clr,
//   key_ready_o             C eq, D mul, E sub, F add)
//   alu_answer_i            21-bit signed ALU result
//   operand_a_o/operand_b_o 11-bit signed ALU operands
//   operator_o              ALU operator code
//   equal_pulse_o           ALU strobe, ALU computes on rise of bit 4
//   result_o/result_valid_o captured answer and its display flag
//   display_sel_o           00 = A, 01 = B, 10 = result
//   overflow_o              chained result was saturated
//
// Build option: define CALC_CHAIN_EN to let an operator key in SHOW reuse the
// result (saturated to +/-999) as operand A. Otherwise that key is dropped and
// overflow_o is tied to 0.
module calc_sequencer #(
  parameter int unsigned MAX_DIGITS = 3
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               key_valid_i,
  input  logic [3:0]         key_code_i,
  output logic               key_ready_o,
  input  logic signed [20:0] alu_answer_i,
  output logic signed [10:0] operand_a_o,
  output logic signed [10:0] operand_b_o,
  output logic [3:0]         operator_o,
  output logic [4:0]         equal_pulse_o,
  output logic signed [20:0] result_o,
  output logic               result_valid_o,
  output logic [1:0]         display_sel_o,
  output logic               overflow_o
);

  localparam logic [1:0] StEnterA = 2'd0;
  localparam logic [1:0] StEnterB = 2'd1;
  localparam logic [1:0] StCalc   = 2'd2;
  localparam logic [1:0] StShow   = 2'd3;

  localparam logic [3:0] KeyNeg = 4'hA;
  localparam logic [3:0] KeyClr = 4'hB;
  localparam logic [3:0] KeyEq  = 4'hC;
  localparam logic [3:0] OpAdd  = 4'hF;

  // Magnitude register sized for operands up to 999.
  localparam int unsigned MagW = 10;
  localparam int unsigned CntW = $clog2(MAX_DIGITS + 1);

  logic [1:0]         state_q, state_d;
  logic [MagW-1:0]    mag_a_q, mag_a_d, mag_b_q, mag_b_d;
  logic               sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [CntW-1:0]    cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [3:0]         op_q, op_d;
  logic [4:0]         pulse_q, pulse_d;
  logic signed [20:0] result_q, result_d;
  logic               rv_q, rv_d;

  logic            key_acc, is_digit, is_op;
  logic [13:0]     mag_a_ext, mag_b_ext;

  assign key_ready_o = (state_q != StCalc);
  assign key_acc     = key_valid_i && key_ready_o;
  assign is_digit    = (key_code_i <= 4'd9);
  assign is_op       = (key_code_i >= 4'hD);

  assign mag_a_ext = (14'(mag_a_q) * 14'd10) + 14'(key_code_i);
  assign mag_b_ext = (14'(mag_b_q) * 14'd10) + 14'(key_code_i);

`ifdef CALC_CHAIN_EN
  localparam logic signed [20:0] SatMag = 21'(10 ** MAX_DIGITS - 1);

  logic               overflow_q, overflow_d;
  logic signed [20:0] res_abs;
  logic               chain_sat;
  logic [MagW-1:0]    chain_mag;

  assign res_abs   = result_q[20] ? -result_q : result_q;
  assign chain_sat = (res_abs > SatMag);
  assign chain_mag = chain_sat ? MagW'(SatMag) : MagW'(res_abs);
`endif

  always_comb begin
    state_d  = state_q;
    mag_a_d  = mag_a_q;
    mag_b_d  = mag_b_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    cnt_a_d  = cnt_a_q;
    cnt_b_d  = cnt_b_q;
    op_d     = op_q;
    pulse_d  = pulse_q;
    result_d = result_q;
    rv_d     = rv_q;
`ifdef CALC_CHAIN_EN
    overflow_d = overflow_q;
`endif

    // Clear, and a digit in SHOW, both start from a fully wiped state.
    if (key_acc && (key_code_i == KeyClr || (state_q == StShow && is_digit))) begin
      state_d  = StEnterA;
      mag_a_d  = '0;
      mag_b_d  = '0;
      sign_a_d = 1'b0;
      sign_b_d = 1'b0;
      cnt_a_d  = '0;
      cnt_b_d  = '0;
      op_d     = OpAdd;
      pulse_d  = '0;
      result_d = '0;
      rv_d     = 1'b0;
`ifdef CALC_CHAIN_EN
      overflow_d = 1'b0;
`endif
      if (key_code_i != KeyClr) begin
        mag_a_d = MagW'(key_code_i);
        cnt_a_d = CntW'(1);
      end
    end else begin
      unique case (state_q)
        StEnterA: begin
          if (key_acc) begin
            if (is_digit) begin
              if (cnt_a_q < CntW'(MAX_DIGITS)) begin
                mag_a_d = MagW'(mag_a_ext);
                cnt_a_d = cnt_a_q + CntW'(1);
              end
            end else if (key_code_i == KeyNeg) begin
              sign_a_d = ~sign_a_q;
            end else if (is_op) begin
              op_d    = key_code_i;
              state_d = StEnterB;
            end
          end
        end
        StEnterB: begin
          if (key_acc) begin
            if (is_digit) begin
              if (cnt_b_q < CntW'(MAX_DIGITS)) begin
                mag_b_d = MagW'(mag_b_ext);
                cnt_b_d = cnt_b_q + CntW'(1);
              end
            end else if (key_code_i == KeyNeg) begin
              sign_b_d = ~sign_b_q;
            end else if (is_op) begin
              // Operator can only be changed before B has any digits.
              if (cnt_b_q == '0) op_d = key_code_i;
            end else if (key_code_i == KeyEq) begin
              state_d = StCalc;
              pulse_d = 5'b00001;
            end
          end
        end
        StCalc: begin
          // ALU latched on the rise of bit 4; its answer is ready one cycle later.
          if (pulse_q[4]) begin
            result_d = alu_answer_i;
            rv_d     = 1'b1;
            pulse_d  = '0;
            state_d  = StShow;
          end else begin
            pulse_d = {pulse_q[3:0], 1'b1};
          end
        end
        StShow: begin
`ifdef CALC_CHAIN_EN
          if (key_acc && is_op) begin
            mag_a_d    = chain_mag;
            sign_a_d   = result_q[20];
            cnt_a_d    = CntW'(MAX_DIGITS);
            mag_b_d    = '0;
            sign_b_d   = 1'b0;
            cnt_b_d    = '0;
            op_d       = key_code_i;
            rv_d       = 1'b0;
            overflow_d = chain_sat;
            state_d    = StEnterB;
          end
`endif
        end
        default: state_d = StEnterA;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= StEnterA;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      cnt_a_q  <= '0;
      cnt_b_q  <= '0;
      op_q     <= OpAdd;
      pulse_q  <= '0;
      result_q <= '0;
      rv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      mag_a_q  <= mag_a_d;
      mag_b_q  <= mag_b_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      cnt_a_q  <= cnt_a_d;
      cnt_b_q  <= cnt_b_d;
      op_q     <= op_d;
      pulse_q  <= pulse_d;
      result_q <= result_d;
      rv_q     <= rv_d;
    end
  end

`ifdef CALC_CHAIN_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) overflow_q <= 1'b0;
    else         overflow_q <= overflow_d;
  end
  assign overflow_o = overflow_q;
`else
  assign overflow_o = 1'b0;
`endif

  // -0 naturally comes out as 0.
  assign operand_a_o = sign_a_q ? -$signed({1'b0, mag_a_q}) : $signed({1'b0, mag_a_q});
  assign operand_b_o = sign_b_q ? -$signed({1'b0, mag_b_q}) : $signed({1'b0, mag_b_q});

  assign operator_o     = op_q;
  assign equal_pulse_o  = pulse_q;
  assign result_o       = result_q;
  assign result_valid_o = rv_q;
  assign display_sel_o  = (state_q == StEnterA) ? 2'b00 :
                          (state_q == StEnterB) ? 2'b01 : 2'b10;

endmodule

// File: tb/tb_calc_sequencer.sv
module tb_calc_sequencer;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               key_valid = 1'b0;
  logic [3:0]         key_code = 4'h0;
  logic               key_ready;
  logic signed [20:0] alu_answer = '0;
  logic signed [10:0] operand_a, operand_b;
  logic [3:0]         operator_code;
  logic [4:0]         equal_pulse;
  logic signed [20:0] result;
  logic               result_valid;
  logic [1:0]         display_sel;
  logic               overflow;

  int n_chk = 0;
  int n_bad = 0;

  localparam logic [3:0] KNeg = 4'hA, KClr = 4'hB, KEq = 4'hC;
  localparam logic [3:0] KMul = 4'hD, KSub = 4'hE, KAdd = 4'hF;

  calc_sequencer #(.MAX_DIGITS(3)) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .key_valid_i    (key_valid),
    .key_code_i     (key_code),
    .key_ready_o    (key_ready),
    .alu_answer_i   (alu_answer),
    .operand_a_o    (operand_a),
    .operand_b_o    (operand_b),
    .operator_o     (operator_code),
    .equal_pulse_o  (equal_pulse),
    .result_o       (result),
    .result_valid_o (result_valid),
    .display_sel_o  (display_sel),
    .overflow_o     (overflow)
  );

  always #5 clk = ~clk;

  // ALU stand-in: computes on the rising edge of strobe bit 4.
  always @(posedge equal_pulse[4]) begin
    longint a, b;
    a = operand_a;
    b = operand_b;
    case (operator_code)
      KMul:    alu_answer = 21'(a * b);
      KSub:    alu_answer = 21'(a - b);
      default: alu_answer = 21'(a + b);
    endcase
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic press_w(input logic [3:0] code, output int waited);
    waited = 0;
    key_code  = code;
    key_valid = 1'b1;
    while (!key_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("key_ready_before_accept", key_ready, 1);
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  task automatic press(input logic [3:0] code);
    int w;
    press_w(code, w);
  endtask

  task automatic wait_result();
    int n = 0;
    while (!result_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("result_valid_timeout", result_valid, 1);
  endtask

  initial begin
    int w;
    logic [4:0] pulse_exp [5];
    pulse_exp[0] = 5'b00001; pulse_exp[1] = 5'b00011; pulse_exp[2] = 5'b00111;
    pulse_exp[3] = 5'b01111; pulse_exp[4] = 5'b11111;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    chk("rst_a", operand_a, 0);
    chk("rst_b", operand_b, 0);
    chk("rst_op", operator_code, 15);
    chk("rst_pulse", equal_pulse, 0);
    chk("rst_result", result, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_sel", display_sel, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ready", key_ready, 1);

    // 12 + 34 with strobe timing
    press(4'd1); press(4'd2);
    chk("a_12", operand_a, 12);
    press(KAdd);
    chk("sel_b", display_sel, 1);
    press(4'd3); press(4'd4);
    chk("b_34", operand_b, 34);
    press(KEq);
    for (int i = 0; i < 5; i++) begin
      chk("pulse_seq", equal_pulse, pulse_exp[i]);
      chk("calc_ready", key_ready, 0);
      chk("calc_sel", display_sel, 2);
      chk("calc_a_hold", operand_a, 12);
      chk("calc_b_hold", operand_b, 34);
      chk("calc_rv", result_valid, 0);
      @(posedge clk); #1;
    end
    chk("res_46", result, 46);
    chk("rv_46", result_valid, 1);
    chk("pulse_clr", equal_pulse, 0);
    chk("ready_back", key_ready, 1);

    // -5 * 7
    press(KClr);
    press(4'd5); press(KNeg);
    chk("a_m5", operand_a, -5);
    press(KMul);
    chk("op_mul", operator_code, 13);
    press(4'd7); press(KEq);
    wait_result();
    chk("res_m35", result, -35);

    // Digit in SHOW starts a new A; 999 * 999
    press(4'd9);
    chk("show_digit_a", operand_a, 9);
    chk("show_digit_rv", result_valid, 0);
    chk("show_digit_sel", display_sel, 0);
    press(4'd9); press(4'd9); press(KMul);
    press(4'd9); press(4'd9); press(4'd9); press(KEq);
    wait_result();
    chk("res_998001", result, 998001);

`ifdef CALC_CHAIN_EN
    press(KAdd);
    chk("chain_a", operand_a, 999);
    chk("chain_ovf", overflow, 1);
    chk("chain_sel", display_sel, 1);
    chk("chain_b", operand_b, 0);
    press(4'd5);
    chk("chain_no_digit", operand_a, 999);
    chk("chain_b5", operand_b, 5);
    press(KEq);
    wait_result();
    chk("chain_res", result, 1004);
    press(KClr);
    chk("chain_clr_ovf", overflow, 0);
`else
    press(KAdd);
    chk("nochain_sel", display_sel, 2);
    chk("nochain_rv", result_valid, 1);
    chk("nochain_res", result, 998001);
    chk("nochain_ovf", overflow, 0);
    press(KClr);
`endif

    // Digit limit and operator overwrite
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    chk("a_123", operand_a, 123);
    press(KSub);
    chk("op_sub", operator_code, 14);
    press(KSub); press(KAdd);
    chk("op_add_over", operator_code, 15);
    press(4'd5);
    press(KSub);
    chk("op_locked", operator_code, 15);
    chk("b_5", operand_b, 5);
    press(KClr);
    chk("clr_a", operand_a, 0);
    chk("clr_b", operand_b, 0);
    chk("clr_op", operator_code, 15);
    chk("clr_sel", display_sel, 0);
    chk("clr_result", result, 0);

    // Negate on zero keeps the sign for later digits; equals in A dropped
    press(KNeg);
    chk("neg_zero", operand_a, 0);
    press(4'd7);
    chk("neg_then_7", operand_a, -7);
    press(KEq);
    chk("eq_in_a_sel", display_sel, 0);
    chk("eq_in_a_ready", key_ready, 1);

    // Reset mid-CALC
    press(KSub); press(4'd2); press(KEq);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_pulse", equal_pulse, 5'b00111);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_pulse", equal_pulse, 0);
    chk("midrst_rv", result_valid, 0);
    chk("midrst_ready", key_ready, 1);
    chk("midrst_a", operand_a, 0);
    chk("midrst_b", operand_b, 0);
    chk("midrst_sel", display_sel, 0);

    // Equals held during CALC waits for key_ready, then is dropped in SHOW
    press(4'd1); press(KAdd); press(4'd2); press(KEq);
    press_w(KEq, w);
    chk("held_wait", w, 5);
    chk("held_rv", result_valid, 1);
    chk("held_sel", display_sel, 2);
    chk("held_res", result, 3);
    press(4'd4);
    chk("show4_a", operand_a, 4);
    chk("show4_rv", result_valid, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
